xdma_c2h_stream_arbiter: RTL and testbench

//  Packet-level round-robin arbiter that shares the single XDMA C2H AXI-Stream channel (512b) among
//  NUM_SRC requesters (e.g. UDP/CMAC RX path, loopback path, status/telemetry path).

---
 rtl/xdma_udp_pkg.sv | 15 +
 rtl/xdma_c2h_stream_arbiter_if.sv | 35 +++
 rtl/xdma_c2h_stream_arbiter_skid.sv | 58 +++++
 rtl/xdma_c2h_stream_arbiter.sv | 124 ++++++++++++
 tb/tb_xdma_c2h_stream_arbiter.sv | 334 +++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/xdma_udp_pkg.sv
// Shared widths and arbiter state type for the XDMA C2H stream path.
package xdma_udp_pkg;

    localparam int XDMA_AXIS_TDATA_WIDTH = 512;
    localparam int XDMA_AXIS_TKEEP_WIDTH = 64;
    localparam int XDMA_AXIS_TUSER_WIDTH = 1;

    typedef enum logic {ARB_IDLE, ARB_LOCKED} arb_state_t;

    // Index width that stays legal (>=1 bit) even for a single source.
    function automatic int idx_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/xdma_c2h_stream_arbiter_if.sv
// Requester streams plus merged C2H stream. The slave modport is the arbiter side;
// the master modport is the side that drives the sources and sinks the merged stream.
interface xdma_c2h_stream_arbiter_if
    import xdma_udp_pkg::*;
#(
    parameter int NUM_SRC = 2,
    parameter int TDATA_W = XDMA_AXIS_TDATA_WIDTH,
    parameter int TKEEP_W = XDMA_AXIS_TKEEP_WIDTH,
    parameter int TUSER_W = XDMA_AXIS_TUSER_WIDTH
);
    logic [NUM_SRC-1:0]         s_axis_tvalid;
    logic [NUM_SRC-1:0]         s_axis_tready;
    logic [NUM_SRC*TDATA_W-1:0] s_axis_tdata;
    logic [NUM_SRC*TKEEP_W-1:0] s_axis_tkeep;
    logic [NUM_SRC-1:0]         s_axis_tlast;
    logic [NUM_SRC*TUSER_W-1:0] s_axis_tuser;

    logic                       m_axis_tvalid;
    logic                       m_axis_tready;
    logic [TDATA_W-1:0]         m_axis_tdata;
    logic [TKEEP_W-1:0]         m_axis_tkeep;
    logic                       m_axis_tlast;
    logic [TUSER_W-1:0]         m_axis_tuser;

    modport slave (
        input  s_axis_tvalid, s_axis_tdata, s_axis_tkeep, s_axis_tlast, s_axis_tuser, m_axis_tready,
        output s_axis_tready, m_axis_tvalid, m_axis_tdata, m_axis_tkeep, m_axis_tlast, m_axis_tuser
    );

    modport master (
        output s_axis_tvalid, s_axis_tdata, s_axis_tkeep, s_axis_tlast, s_axis_tuser, m_axis_tready,
        input  s_axis_tready, m_axis_tvalid, m_axis_tdata, m_axis_tkeep, m_axis_tlast, m_axis_tuser
    );

endinterface

// File: rtl/xdma_c2h_stream_arbiter_skid.sv
// axis_skid_buf: 2-entry registered AXIS slice; in_ready depends only on local state,
// so the upstream path is cut while full 1 beat/cycle throughput is kept.
module axis_skid_buf #(
    parameter int DATA_W = 512,
    parameter int KEEP_W = 64,
    parameter int USER_W = 1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_data,
    input  logic [KEEP_W-1:0] in_keep,
    input  logic              in_last,
    input  logic [USER_W-1:0] in_user,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_data,
    output logic [KEEP_W-1:0] out_keep,
    output logic              out_last,
    output logic [USER_W-1:0] out_user
);
    localparam int PW = DATA_W + KEEP_W + USER_W + 1;

    logic [PW-1:0] in_pl;
    logic [PW-1:0] out_pl;
    logic [PW-1:0] skid_pl;
    logic          out_v;
    logic          skid_v;

    assign in_pl     = {in_last, in_user, in_keep, in_data};
    assign in_ready  = ~skid_v;
    assign out_valid = out_v;
    assign {out_last, out_user, out_keep, out_data} = out_pl;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_v   <= 1'b0;
            skid_v  <= 1'b0;
            out_pl  <= '0;
            skid_pl <= '0;
        end else if (!out_v || out_ready) begin
            // Output slot frees up: the parked beat goes first to keep order.
            if (skid_v) begin
                out_pl <= skid_pl;
                out_v  <= 1'b1;
                skid_v <= 1'b0;
            end else begin
                out_v <= in_valid;
                if (in_valid) out_pl <= in_pl;
            end
        end else if (in_valid && !skid_v) begin
            skid_pl <= in_pl;
            skid_v  <= 1'b1;
        end
    end

endmodule

// File: rtl/xdma_c2h_stream_arbiter.sv
// Packet-locked round-robin arbiter merging NUM_SRC AXIS sources onto the C2H stream.
// Optional per-source packet counters when XDMA_C2H_ARB_PKT_CNT_EN is defined.
//
//   state      | meaning
//   ARB_IDLE   | no lock, all tready low; picks the next valid source round-robin
//   ARB_LOCKED | granted source feeds the skid buffer until its tlast beat is accepted
module xdma_c2h_stream_arbiter
    import xdma_udp_pkg::*;
#(
    parameter int NUM_SRC = 2,
    parameter int TDATA_W = XDMA_AXIS_TDATA_WIDTH,
    parameter int TKEEP_W = XDMA_AXIS_TKEEP_WIDTH,
    parameter int TUSER_W = XDMA_AXIS_TUSER_WIDTH,
    parameter int CNT_W   = 32,
    localparam int IDX_W  = idx_width(NUM_SRC)
) (
    input  logic                      xdma_axi_aclk,
    input  logic                      xdma_axi_aresetn,
    xdma_c2h_stream_arbiter_if.slave  axis,
    output logic [IDX_W-1:0]          grant_idx,
    output logic                      arb_busy
`ifdef XDMA_C2H_ARB_PKT_CNT_EN
    ,
    output logic [NUM_SRC*CNT_W-1:0]  pkt_cnt
`endif
);
    arb_state_t         state;
    logic [IDX_W-1:0]   rr_ptr;
    logic               sel_valid;
    logic [TDATA_W-1:0] sel_data;
    logic [TKEEP_W-1:0] sel_keep;
    logic               sel_last;
    logic [TUSER_W-1:0] sel_user;
    logic               push;
    logic               skid_ready;
    logic               accept;
    logic               pkt_done;

    // First requester at or after ptr, wrapping; later offsets are overwritten by earlier ones.
    function automatic logic [IDX_W-1:0] rr_winner(input logic [NUM_SRC-1:0] req,
                                                   input logic [IDX_W-1:0]   ptr);
        logic [IDX_W-1:0] win;
        int               idx;
        win = '0;
        for (int i = NUM_SRC - 1; i >= 0; i--) begin
            idx = (int'(ptr) + i) % NUM_SRC;
            if (req[idx]) win = IDX_W'(idx);
        end
        return win;
    endfunction

    always_comb begin
        sel_valid = axis.s_axis_tvalid[grant_idx];
        sel_data  = axis.s_axis_tdata[grant_idx*TDATA_W +: TDATA_W];
        sel_keep  = axis.s_axis_tkeep[grant_idx*TKEEP_W +: TKEEP_W];
        sel_last  = axis.s_axis_tlast[grant_idx];
        sel_user  = axis.s_axis_tuser[grant_idx*TUSER_W +: TUSER_W];
        axis.s_axis_tready = '0;
        if (state == ARB_LOCKED) axis.s_axis_tready[grant_idx] = skid_ready;
    end

    assign push     = (state == ARB_LOCKED) && sel_valid;
    assign accept   = push && skid_ready;
    assign pkt_done = accept && sel_last;

    always_ff @(posedge xdma_axi_aclk or negedge xdma_axi_aresetn) begin
        if (!xdma_axi_aresetn) begin
            state     <= ARB_IDLE;
            rr_ptr    <= '0;
            grant_idx <= '0;
            arb_busy  <= 1'b0;
        end else begin
            case (state)
                ARB_IDLE: begin
                    if (|axis.s_axis_tvalid) begin
                        grant_idx <= rr_winner(axis.s_axis_tvalid, rr_ptr);
                        arb_busy  <= 1'b1;
                        state     <= ARB_LOCKED;
                    end
                end
                ARB_LOCKED: begin
                    if (pkt_done) begin
                        rr_ptr   <= IDX_W'((int'(grant_idx) + 1) % NUM_SRC);
                        arb_busy <= 1'b0;
                        state    <= ARB_IDLE;
                    end
                end
                default: state <= ARB_IDLE;
            endcase
        end
    end

`ifdef XDMA_C2H_ARB_PKT_CNT_EN
    always_ff @(posedge xdma_axi_aclk or negedge xdma_axi_aresetn) begin
        if (!xdma_axi_aresetn) begin
            pkt_cnt <= '0;
        end else if (pkt_done) begin
            pkt_cnt[grant_idx*CNT_W +: CNT_W] <= pkt_cnt[grant_idx*CNT_W +: CNT_W] + CNT_W'(1);
        end
    end
`endif

    axis_skid_buf #(
        .DATA_W (TDATA_W),
        .KEEP_W (TKEEP_W),
        .USER_W (TUSER_W)
    ) u_skid (
        .clk       (xdma_axi_aclk),
        .rst_n     (xdma_axi_aresetn),
        .in_valid  (push),
        .in_ready  (skid_ready),
        .in_data   (sel_data),
        .in_keep   (sel_keep),
        .in_last   (sel_last),
        .in_user   (sel_user),
        .out_valid (axis.m_axis_tvalid),
        .out_ready (axis.m_axis_tready),
        .out_data  (axis.m_axis_tdata),
        .out_keep  (axis.m_axis_tkeep),
        .out_last  (axis.m_axis_tlast),
        .out_user  (axis.m_axis_tuser)
    );

endmodule

// File: tb/tb_xdma_c2h_stream_arbiter.sv
// Directed bench for xdma_c2h_stream_arbiter; counter checks compile in with XDMA_C2H_ARB_PKT_CNT_EN.
`timescale 1ns/1ps
module tb_xdma_c2h_stream_arbiter;
    import xdma_udp_pkg::*;

    localparam int NUM_SRC = 2;
    localparam int TDATA_W = XDMA_AXIS_TDATA_WIDTH;
    localparam int TKEEP_W = 64;
    localparam int TUSER_W = 1;
    localparam int CNT_W   = 32;

    typedef struct packed {
        logic [3:0]  src;
        logic [11:0] pkt;
        logic [7:0]  beat;
        logic        last;
    } beat_t;

    typedef struct {
        beat_t b;
        int    cyc;
        logic  ok;
    } obs_t;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    xdma_c2h_stream_arbiter_if #(.NUM_SRC(NUM_SRC), .TDATA_W(TDATA_W), .TKEEP_W(TKEEP_W),
                                 .TUSER_W(TUSER_W)) axis();
    logic [0:0] grant_idx;
    logic       arb_busy;
`ifdef XDMA_C2H_ARB_PKT_CNT_EN
    logic [NUM_SRC*CNT_W-1:0] pkt_cnt;
`endif

    xdma_c2h_stream_arbiter #(.NUM_SRC(NUM_SRC), .TDATA_W(TDATA_W), .TKEEP_W(TKEEP_W),
                              .TUSER_W(TUSER_W), .CNT_W(CNT_W)) dut (
        .xdma_axi_aclk    (clk),
        .xdma_axi_aresetn (rst_n),
        .axis             (axis),
        .grant_idx        (grant_idx),
        .arb_busy         (arb_busy)
`ifdef XDMA_C2H_ARB_PKT_CNT_EN
        ,
        .pkt_cnt          (pkt_cnt)
`endif
    );

    int    checks = 0;
    int    errors = 0;
    beat_t plan_q [NUM_SRC][$];
    int    pkt_id [NUM_SRC] = '{0, 0};
    logic  gap_en [NUM_SRC] = '{1'b0, 1'b0};
    int    mt_mode = 0;
    int    pos [NUM_SRC] = '{0, 0};
    logic  acc [NUM_SRC] = '{1'b0, 1'b0};
    obs_t  out_q [$];
    int    stall_viol = 0;
    int    cyc = 0;
    logic               hold_v = 1'b0;
    logic [TDATA_W-1:0] hold_d;
    logic [TKEEP_W-1:0] hold_k;
    logic               hold_l;
    logic [TUSER_W-1:0] hold_u;

    function automatic logic [TDATA_W-1:0] mk_data(input beat_t b);
        logic [TDATA_W-1:0] d;
        for (int k = 0; k < TDATA_W / 32; k++) d[k*32 +: 32] = {b, 7'h2B} ^ 32'(k * 32'h0101_0101);
        return d;
    endfunction
    function automatic logic [TKEEP_W-1:0] mk_keep(input beat_t b);
        return {8{b.pkt[3:0], b.beat[3:0]}};
    endfunction
    function automatic logic [TUSER_W-1:0] mk_user(input beat_t b);
        return TUSER_W'(b.beat[0] ^ b.src[0]);
    endfunction
    function automatic beat_t mkb(input int s, input int p, input int k, input logic l);
        beat_t b;
        b.src = 4'(s); b.pkt = 12'(p); b.beat = 8'(k); b.last = l;
        return b;
    endfunction

    // Sources, sink and output monitor; inputs change on the falling edge only.
    always @(negedge clk) begin
        beat_t b;
        obs_t  o;
        cyc++;
        for (int i = 0; i < NUM_SRC; i++) begin
            if (!rst_n) begin
                pos[i] = plan_q[i].size();
                acc[i] = 1'b0;
                axis.s_axis_tvalid[i] = 1'b0;
                axis.s_axis_tlast[i]  = 1'b0;
                axis.s_axis_tdata[i*TDATA_W +: TDATA_W] = '0;
                axis.s_axis_tkeep[i*TKEEP_W +: TKEEP_W] = '0;
                axis.s_axis_tuser[i*TUSER_W +: TUSER_W] = '0;
            end else begin
                if (acc[i]) pos[i]++;
                if (!axis.s_axis_tvalid[i] || acc[i]) begin
                    if (pos[i] < plan_q[i].size() && (!gap_en[i] || $urandom_range(1, 0) == 1)) begin
                        b = plan_q[i][pos[i]];
                        axis.s_axis_tvalid[i] = 1'b1;
                        axis.s_axis_tlast[i]  = b.last;
                        axis.s_axis_tdata[i*TDATA_W +: TDATA_W] = mk_data(b);
                        axis.s_axis_tkeep[i*TKEEP_W +: TKEEP_W] = mk_keep(b);
                        axis.s_axis_tuser[i*TUSER_W +: TUSER_W] = mk_user(b);
                    end else begin
                        axis.s_axis_tvalid[i] = 1'b0;
                    end
                end
            end
        end
        axis.m_axis_tready = (mt_mode == 0) ? 1'b1 : (mt_mode == 1) ? 1'($urandom_range(1, 0)) : 1'b0;
        if (rst_n && hold_v) begin
            if (!(axis.m_axis_tvalid && axis.m_axis_tdata == hold_d && axis.m_axis_tkeep == hold_k &&
                  axis.m_axis_tlast == hold_l && axis.m_axis_tuser == hold_u)) stall_viol++;
        end
        hold_v = rst_n && axis.m_axis_tvalid && !axis.m_axis_tready;
        hold_d = axis.m_axis_tdata;
        hold_k = axis.m_axis_tkeep;
        hold_l = axis.m_axis_tlast;
        hold_u = axis.m_axis_tuser;
        if (rst_n && axis.m_axis_tvalid && axis.m_axis_tready) begin
            o.b   = axis.m_axis_tdata[31:7];
            o.cyc = cyc;
            o.ok  = (axis.m_axis_tdata == mk_data(o.b)) && (axis.m_axis_tkeep == mk_keep(o.b)) &&
                    (axis.m_axis_tuser == mk_user(o.b)) && (axis.m_axis_tlast == o.b.last);
            out_q.push_back(o);
        end
        for (int i = 0; i < NUM_SRC; i++)
            acc[i] = rst_n && axis.s_axis_tvalid[i] && axis.s_axis_tready[i];
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step(input int n);
        repeat (n) begin @(negedge clk); #1; end
    endtask

    task automatic send_pkt(input int s, input int len);
        for (int k = 0; k < len; k++) plan_q[s].push_back(mkb(s, pkt_id[s], k, k == len - 1));
        pkt_id[s]++;
    endtask

    task automatic wait_out(input string tag, input int n, input int budget);
        int t;
        t = 0;
        while (out_q.size() < n && t < budget) begin step(1); t++; end
        chk(tag, out_q.size() >= n, 1);
    endtask

    initial begin
        int    base, cnt, bad, viol, total, s, cur, p0, st0;
        int    ptr [NUM_SRC];
        obs_t  o;

        // Reset
        step(5);
        chk("rst_m_tvalid", axis.m_axis_tvalid, 0);
        chk("rst_m_payload", {axis.m_axis_tdata == '0, axis.m_axis_tkeep == '0, axis.m_axis_tlast, axis.m_axis_tuser}, 4'b1100);
        chk("rst_s_tready", axis.s_axis_tready, 0);
        chk("rst_grant_busy", {grant_idx, arb_busy}, 0);
`ifdef XDMA_C2H_ARB_PKT_CNT_EN
        chk("rst_pkt_cnt", pkt_cnt, 0);
`endif
        rst_n = 1'b1;
        step(4);
        chk("idle_busy", arb_busy, 0);

        // 3-beat packet on src0: 1 IDLE cycle + 1 skid cycle of latency
        base = out_q.size();
        p0 = pkt_id[0];
        send_pkt(0, 3);
        step(1);
        cnt = 0;
        while (!axis.m_axis_tvalid && cnt < 20) begin step(1); cnt++; end
        chk("t2_latency", cnt, 2);
        chk("t2_first_data", axis.m_axis_tdata == mk_data(mkb(0, p0, 0, 1'b0)), 1);
        wait_out("t2_timeout", base + 3, 50);
        bad = 0;
        for (int k = 0; k < 3; k++) begin
            o = out_q[base + k];
            if (o.b != mkb(0, p0, k, k == 2) || !o.ok) bad++;
        end
        chk("t2_beats", bad, 0);
        chk("t2_busy_after", arb_busy, 0);
        chk("t2_rr_ptr", dut.rr_ptr, 1);

        // Single-beat packet on src1 brings rr_ptr back to 0
        base = out_q.size();
        send_pkt(1, 1);
        wait_out("t_single_timeout", base + 1, 50);
        step(2);
        chk("t_single_beat", out_q[base].b == mkb(1, pkt_id[1] - 1, 0, 1'b1) && out_q[base].ok, 1);
        chk("t_single_grant", grant_idx, 1);
        chk("t_single_state", {arb_busy, dut.rr_ptr}, 0);

        // Both sources continuously busy: alternate, no interleave, one bubble between packets
        base = out_q.size();
        for (int p = 0; p < 3; p++) begin send_pkt(0, 4); send_pkt(1, 4); end
        wait_out("t3_timeout", base + 24, 300);
        bad = 0;
        for (int p = 0; p < 6; p++) begin
            chk($sformatf("t3_order_pkt%0d", p), out_q[base + p*4].b.src, p % 2);
            for (int k = 0; k < 4; k++) begin
                o = out_q[base + p*4 + k];
                if (o.b.src != 4'(p % 2) || o.b.beat != 8'(k) || o.b.last != (k == 3) || !o.ok) bad++;
                if (k > 0 && o.cyc - out_q[base + p*4 + k - 1].cyc != 1) bad++;
                if (k == 0 && p > 0 && o.cyc - out_q[base + p*4 - 1].cyc != 2) bad++;
            end
        end
        chk("t3_form_timing", bad, 0);

        // Src1 with tvalid gaps keeps the lock while src0 waits
        base = out_q.size();
        gap_en[1] = 1'b1;
        send_pkt(1, 6);
        cnt = 0;
        while (!(arb_busy && grant_idx == 1) && cnt < 50) begin step(1); cnt++; end
        chk("t4_grant_src1", {arb_busy, grant_idx}, 2'b11);
        send_pkt(0, 2);
        viol = 0;
        cnt = 0;
        while (arb_busy && cnt < 400) begin
            if (axis.s_axis_tready[0] || grant_idx != 1) viol++;
            step(1); cnt++;
        end
        chk("t4_src0_blocked", viol, 0);
        chk("t4_lock_released", arb_busy, 0);
        wait_out("t4_timeout", base + 8, 100);
        bad = 0;
        for (int k = 0; k < 8; k++) begin
            o = out_q[base + k];
            if (o.b.src != ((k < 6) ? 4'd1 : 4'd0) || !o.ok) bad++;
        end
        chk("t4_order", bad, 0);
        gap_en[1] = 1'b0;

        // Sink stalled: skid fills with exactly 2 beats, then tready drops
        base = out_q.size();
        mt_mode = 2;
        step(1);
        st0 = pos[0];
        send_pkt(0, 5);
        step(12);
        chk("stall_accepted", pos[0] - st0, 2);
        chk("stall_s_tready", axis.s_axis_tready[0], 0);
        chk("stall_m_tvalid", axis.m_axis_tvalid, 1);
        chk("stall_no_out", out_q.size(), base);
        mt_mode = 0;
        wait_out("stall_timeout", base + 5, 50);
        bad = 0;
        for (int k = 0; k < 5; k++)
            if (out_q[base + k].b != mkb(0, pkt_id[0] - 1, k, k == 4) || !out_q[base + k].ok) bad++;
        chk("stall_beats", bad, 0);

        // Random sink backpressure and source gaps: per-source scoreboard
        base = out_q.size();
        for (int i = 0; i < NUM_SRC; i++) begin ptr[i] = plan_q[i].size(); gap_en[i] = 1'b1; end
        mt_mode = 1;
        total = 0;
        for (int k = 0; k < 200; k++) begin
            s = $urandom_range(1, 0);
            cnt = $urandom_range(5, 1);
            send_pkt(s, cnt);
            total += cnt;
        end
        wait_out("t5_timeout", base + total, 8000);
        bad = 0;
        cur = -1;
        for (int j = base; j < out_q.size(); j++) begin
            o = out_q[j];
            s = int'(o.b.src);
            if (s >= NUM_SRC) begin bad++; continue; end
            if (cur != -1 && s != cur) bad++;
            if (!o.ok) bad++;
            if (ptr[s] >= plan_q[s].size() || o.b != plan_q[s][ptr[s]]) bad++;
            else ptr[s]++;
            cur = o.b.last ? -1 : s;
        end
        chk("t5_scoreboard", bad, 0);
        chk("t5_src0_all", ptr[0], plan_q[0].size());
        chk("t5_src1_all", ptr[1], plan_q[1].size());
        chk("t5_stall_stable", stall_viol, 0);
        mt_mode = 0;
        for (int i = 0; i < NUM_SRC; i++) gap_en[i] = 1'b0;
        step(5);

        // Reset mid-packet drops the output at once
        send_pkt(0, 8);
        cnt = 0;
        while (!axis.m_axis_tvalid && cnt < 20) begin step(1); cnt++; end
        step(2);
`ifdef XDMA_C2H_ARB_PKT_CNT_EN
        chk("cnt_before_rst0", pkt_cnt[0 +: CNT_W], pkt_id[0] - 1);
        chk("cnt_before_rst1", pkt_cnt[CNT_W +: CNT_W], pkt_id[1]);
`endif
        chk("mid_rst_pre_tvalid", axis.m_axis_tvalid, 1);
        #2 rst_n = 1'b0;
        #1;
        chk("mid_rst_m_tvalid", axis.m_axis_tvalid, 0);
        chk("mid_rst_state", {arb_busy, grant_idx, axis.s_axis_tready}, 0);
`ifdef XDMA_C2H_ARB_PKT_CNT_EN
        chk("mid_rst_pkt_cnt", pkt_cnt, 0);
`endif
        step(3);
        rst_n = 1'b1;
        step(4);
        chk("post_rst_idle", {arb_busy, axis.m_axis_tvalid}, 0);

`ifdef XDMA_C2H_ARB_PKT_CNT_EN
        // 10 packets on src0 and 7 on src1 after reset
        base = out_q.size();
        total = 0;
        for (int k = 0; k < 10; k++) begin cnt = $urandom_range(3, 1); send_pkt(0, cnt); total += cnt; end
        for (int k = 0; k < 7; k++) begin cnt = $urandom_range(3, 1); send_pkt(1, cnt); total += cnt; end
        wait_out("t6_timeout", base + total, 500);
        step(3);
        chk("t6_pkt_cnt0", pkt_cnt[0 +: CNT_W], 10);
        chk("t6_pkt_cnt1", pkt_cnt[CNT_W +: CNT_W], 7);
`endif

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
